muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/HI/LO width (even, >= 8).
REQ-002 Parameter DIV0_LO_ONES, default 1, 1 = divide-by-zero writes all-ones to LO, 0 = writes zero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled on rising edge of clk.
REQ-006 op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others reserved.
REQ-007 rs_data  input  XLEN  multiplicand / dividend / mthi-mtlo source.
REQ-008 rt_data  input  XLEN  multiplier / divisor.
REQ-009 flush  input  1  abort in-flight operation.
REQ-010 busy  output  1  iterative operation in flight; the pipeline stalls mfhi/mflo/muldiv issue while high.
REQ-011 done  output  1  one-cycle pulse: HI/LO just updated by mult/div.
REQ-012 hi, lo  output  XLEN each  architectural HI/LO registers, driven directly from flops.

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIX; counter of ceil(log2(XLEN+1)) bits.
REQ-014 IDLE with start=1 and op in {mult, multu}: latch operands, count=0, go to MUL, busy=1 from next cycle.
REQ-015 IDLE with start=1 and op in {div, divu}: latch operands, count=0, go to DIV.
REQ-016 Signed ops (mult, div): latch absolute values and record result signs; unsigned ops latch raw values.
REQ-017 MUL: radix-2 shift-add, one multiplier bit per cycle, XLEN cycles, then FIX.
REQ-018 DIV: restoring divide, one quotient bit per cycle, XLEN cycles, then FIX.
REQ-019 FIX: apply sign correction and load HI/LO on the edge leaving FIX; go to IDLE.
REQ-020 Latency: start accepted at edge E0; busy=1 for exactly XLEN+1 cycles after E0; HI/LO load and busy=0 take effect at edge E(XLEN+1); done=1 for exactly the one cycle following E(XLEN+1).
REQ-021 mult/multu: {HI,LO} = full 2*XLEN-bit product, signed or unsigned per op.
REQ-022 div/divu: LO = quotient truncated toward zero; HI = remainder, sign equal to dividend sign (signed op).
REQ-023 Divisor zero, either div op: HI = rs_data as latched; LO = all ones if DIV0_LO_ONES else zero; same latency as a normal divide.
REQ-024 Signed overflow (dividend = most-negative, divisor = -1): LO = most-negative, HI = 0.
REQ-025 mthi/mtlo in IDLE: HI (resp. LO) = rs_data at that edge; busy stays 0; done stays 0; other register unchanged.
REQ-026 start while busy=1 is ignored (no effect on state, operands or HI/LO).
REQ-027 Reserved op with start=1 is ignored.
REQ-028 flush=1 in any state: go to IDLE next edge, busy=0, done=0, HI/LO unchanged; flush has priority over start in the same cycle.
REQ-029 done never coincides with busy=1.

Reset
REQ-030 rst=1 at a clock edge: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0.
REQ-031 rst has priority over flush and start; reset mid-operation discards the operation, with no HI/LO update.

Verification (XLEN=32)
REQ-032 mult rs=0xFFFFFFFD (-3), rt=7 -> busy 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 multu rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 divu rs=7, rt=0 -> hi=7, lo=0xFFFFFFFF after 33 busy cycles.
REQ-036 mult issued, second start (divu) at cycle 5 -> ignored, product unchanged; separately, flush at cycle 10 -> busy=0 next cycle, hi/lo keep prior values, no done.
REQ-037 mthi rs=0x1234 then mtlo rs=0xABCD -> hi=0x1234, lo=0xABCD, busy never asserted; rst mid-div -> hi=lo=0, done never pulses.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Radix-2 shift-add multiply and restoring divide run on magnitudes; FIX applies signs.
module muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit DIV0_LO_ONES = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);

  // state | meaning
  // IDLE  | waiting for start; mthi/mtlo handled here
  // MUL   | one multiplier bit per cycle, XLEN cycles
  // DIV   | one quotient bit per cycle, XLEN cycles
  // FIX   | sign correction, HI/LO load on the exiting edge
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;

  logic              w_is_mul;
  logic              w_is_div;
  logic              w_signed;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic [XLEN-1:0]   w_rs_abs;
  logic [XLEN-1:0]   w_rt_abs;
  logic              w_last;

  assign w_is_mul = (op == 3'b000) || (op == 3'b001);
  assign w_is_div = (op == 3'b010) || (op == 3'b011);
  assign w_signed = ~op[0];
  assign w_rs_neg = w_signed & rs_data[XLEN-1];
  assign w_rt_neg = w_signed & rt_data[XLEN-1];
  assign w_rs_abs = w_rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign w_rt_abs = w_rt_neg ? (~rt_data + 1'b1) : rt_data;
  assign w_last   = (r_count == CW'(XLEN - 1));

  // Multiply: r_acc = {partial sum, remaining multiplier bits}
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a : {XLEN{1'b0}})};
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: r_acc = {partial remainder, dividend bits / quotient bits}
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN+1:0]   w_div_diff;
  logic              w_div_ok;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_step;
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_div_ok   = ~w_div_diff[XLEN+1];
  assign w_div_rem  = w_div_ok ? w_div_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_div_step = {w_div_rem, r_acc[XLEN-2:0], w_div_ok};

  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_hi_fix;
  logic [XLEN-1:0]   w_lo_fix;
  assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_hi_fix = w_prod_fix[2*XLEN-1:XLEN];
    w_lo_fix = w_prod_fix[XLEN-1:0];
    if (r_is_div) begin
      if (r_b == '0) begin
        // Rebuild the dividend exactly as it was presented
        w_hi_fix = r_neg_r ? (~r_a + 1'b1) : r_a;
        w_lo_fix = {XLEN{DIV0_LO_ONES}};
      end else begin
        w_hi_fix = w_rem_fix;
        w_lo_fix = w_quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_is_mul)      w_state_nxt = S_MUL;
          else if (start && w_is_div) w_state_nxt = S_DIV;
        end
        S_MUL:   if (w_last) w_state_nxt = S_FIX;
        S_DIV:   if (w_last) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && (w_is_mul || w_is_div)) begin
              r_count  <= '0;
              r_a      <= w_rs_abs;
              r_b      <= w_rt_abs;
              r_acc    <= {{XLEN{1'b0}}, (w_is_mul ? w_rt_abs : w_rs_abs)};
              r_is_div <= w_is_div;
              r_neg_q  <= w_rs_neg ^ w_rt_neg;
              r_neg_r  <= w_rs_neg;
            end else if (start && op == 3'b100) begin
              r_hi <= rs_data;
            end else if (start && op == 3'b101) begin
              r_lo <= rs_data;
            end
          end
          S_MUL: begin
            r_acc   <= w_mul_step;
            r_count <= r_count + 1'b1;
          end
          S_DIV: begin
            r_acc   <= w_div_step;
            r_count <= r_count + 1'b1;
          end
          S_FIX: begin
            r_hi    <= w_hi_fix;
            r_lo    <= w_lo_fix;
            r_done  <= 1'b1;
            r_count <= '0;
          end
          default: r_count <= '0;
        endcase
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table, corner-case
// sequences, and random operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit #(.XLEN(32), .DIV0_LO_ONES(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r_hi, output logic [31:0] r_lo);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    r_hi = '0;
    r_lo = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f_op)
      3'd0: begin
        p = 64'(sa * sb);
        r_hi = p[63:32];
        r_lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        r_hi = p[63:32];
        r_lo = p[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          r_hi = a;
          r_lo = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          p = 64'(sq);
          r_lo = p[31:0];
          p = 64'(sr);
          r_hi = p[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin
          r_hi = a;
          r_lo = 32'hFFFF_FFFF;
        end else begin
          r_lo = a / b;
          r_hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] i_op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    op      = i_op;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_busy, input logic [31:0] e_hi,
                           input logic [31:0] e_lo);
    int n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk({name, "_done_while_busy"}, 64'(done), 64'd0);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({name, "_done_pulse"}, 64'(done), 64'd1);
    chk({name, "_hi"}, 64'(hi), 64'(e_hi));
    chk({name, "_lo"}, 64'(lo), 64'(e_lo));
    @(negedge clk);
    chk({name, "_done_clear"}, 64'(done), 64'd0);
  endtask

  task automatic do_move(input logic [2:0] i_op, input logic [31:0] a);
    issue(i_op, a, 32'h0);
    if (i_op == 3'd4) m_hi = a;
    else              m_lo = a;
    @(negedge clk);
    chk("move_busy", 64'(busy), 64'd0);
    chk("move_done", 64'(done), 64'd0);
    chk("move_hi", 64'(hi), 64'(m_hi));
    chk("move_lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [31:0] e_hi, e_lo, a, b;
    logic [2:0]  r_op;

    rst = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{3'd1, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{3'd3, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done($sformatf("vec%0d", i), 33, vecs[i].hi, vecs[i].lo);
      m_hi = vecs[i].hi;
      m_lo = vecs[i].lo;
    end

    do_move(3'd4, 32'h0000_1234);
    do_move(3'd5, 32'h0000_ABCD);
    chk("mthi_mtlo_hi", 64'(hi), 64'h1234);
    chk("mthi_mtlo_lo", 64'(lo), 64'hABCD);

    // second start mid-multiply is ignored
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ign_busy", 64'(busy), 64'd1);
    end
    start = 1'b1; op = 3'd3; rs_data = 32'd99; rt_data = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignored_start", 29, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;

    // flush mid-multiply
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("flush_pre_busy", 64'(busy), 64'd1);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("flush_no_done", 64'(done), 64'd0);
    end

    // flush beats start in the same cycle
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'd4; rs_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 begin flush = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("flush_prio_hi", 64'(hi), 64'(m_hi));
    chk("flush_prio_busy", 64'(busy), 64'd0);

    // reserved op
    issue(3'd6, 32'h5555_5555, 32'd3);
    @(negedge clk);
    chk("reserved_busy", 64'(busy), 64'd0);
    chk("reserved_hi", 64'(hi), 64'(m_hi));
    chk("reserved_lo", 64'(lo), 64'(m_lo));

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = -b;
      if (r_op >= 3'd4) begin
        do_move(r_op, a);
      end else begin
        ref_model(r_op, a, b, e_hi, e_lo);
        issue(r_op, a, b);
        wait_done($sformatf("rnd%0d_op%0d", i, r_op), 33, e_hi, e_lo);
        m_hi = e_hi;
        m_lo = e_lo;
      end
    end

    // reset in the middle of a divide
    issue(3'd2, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 64'(done), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
